// File: rtl/rtc_timebase_counter_pkg.sv
// Shared constants and mode decoding for the stopwatch time base.
// The control block's three strobes collapse into one of four operating modes.
package rtc_pkg;

  localparam int RTC_CLK_DIV_10MS = 1_000_000;
  localparam int RTC_CNT_W        = 24;
  localparam int RTC_PRESC_W      = 20;

  typedef enum logic [1:0] {
    MODE_CLEAR = 2'd0,
    MODE_RUN   = 2'd1,
    MODE_LAP   = 2'd2,
    MODE_STOP  = 2'd3
  } rtc_mode_e;

  // Init dominates; without enable the block is stopped regardless of latch.
  function automatic rtc_mode_e rtc_decode_mode(input logic init,
                                                input logic enb,
                                                input logic latch);
    if (init) begin
      return MODE_CLEAR;
    end else if (!enb) begin
      return MODE_STOP;
    end else if (latch) begin
      return MODE_RUN;
    end else begin
      return MODE_LAP;
    end
  endfunction

endpackage

// File: rtl/rtc_timebase_counter_if.sv
// Control-in / time-out bundle between the trigger block, the time base and the display formatter.
// master = the side driving the control strobes, slave = the time base itself.
interface rtc_timebase_counter_if
  import rtc_pkg::*;
#(
  parameter int CNT_W = RTC_CNT_W
);

  logic             count_init;
  logic             count_enb;
  logic             latch_count;
  logic             tick;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] latched;
  logic             latch_upd;
  logic             overflow;

  modport master (
    output count_init, count_enb, latch_count,
    input  tick, count, latched, latch_upd, overflow
  );

  modport slave (
    input  count_init, count_enb, latch_count,
    output tick, count, latched, latch_upd, overflow
  );

endinterface

// File: rtl/rtc_timebase_counter_prescaler.sv
// Divides i_sclk by CLK_DIV while enabled; wrap_o flags the edge on which the interval completes.
// Holding while disabled preserves the sub-tick fraction across a pause.
module rtc_prescaler
  import rtc_pkg::*;
#(
  parameter int CLK_DIV = RTC_CLK_DIV_10MS,
  parameter int PRESC_W = RTC_PRESC_W
) (
  input  logic i_sclk,
  input  logic i_reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic wrap_o
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(CLK_DIV - 1);

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;

  // Combinational strobe: the parent registers it, so tick and count move together.
  assign wrap_o = enable_i && !clear_i && (presc_q == LAST);

  always_comb begin
    presc_d = presc_q;
    if (clear_i) begin
      presc_d = '0;
    end else if (enable_i) begin
      presc_d = (presc_q == LAST) ? '0 : presc_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/rtc_timebase_counter.sv
// Stopwatch time base: 10 ms tick generation, elapsed-tick counter, lap/display latch
// and sticky overflow. All outputs are registered.
module rtc_timebase_counter
  import rtc_pkg::*;
#(
  parameter int CLK_DIV = RTC_CLK_DIV_10MS,
  parameter int PRESC_W = RTC_PRESC_W,
  parameter int CNT_W   = RTC_CNT_W
) (
  input  logic                  i_sclk,
  input  logic                  i_reset_n,
  rtc_timebase_counter_if.slave bus
);

  rtc_mode_e mode;
  logic      clear;
  logic      run;
  logic      wrap;

  logic             tick_q,      tick_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [CNT_W-1:0] latched_q,   latched_d;
  logic             overflow_q,  overflow_d;
  logic             latch_chg_q, latch_chg_d;
  logic             latch_upd_q;

  assign mode  = rtc_decode_mode(bus.count_init, bus.count_enb, bus.latch_count);
  assign clear = (mode == MODE_CLEAR);
  assign run   = (mode == MODE_RUN) || (mode == MODE_LAP);

  rtc_prescaler #(
    .CLK_DIV (CLK_DIV),
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .i_sclk    (i_sclk),
    .i_reset_n (i_reset_n),
    .clear_i   (clear),
    .enable_i  (run),
    .wrap_o    (wrap)
  );

  always_comb begin
    tick_d     = 1'b0;
    count_d    = count_q;
    latched_d  = latched_q;
    overflow_d = overflow_q;
    if (clear) begin
      count_d    = '0;
      latched_d  = '0;
      overflow_d = 1'b0;
    end else begin
      tick_d = wrap;
      if (wrap) begin
        count_d = count_q + CNT_W'(1);
        if (count_q == '1) begin
          overflow_d = 1'b1;
        end
      end
      // Latch samples the pre-edge count, so the display trails the live count by one cycle.
      if (bus.latch_count) begin
        latched_d = count_q;
      end
    end
    latch_chg_d = (latched_d != latched_q);
  end

  // The update pulse trails the display change by one cycle so the formatter sees a stable value.
  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tick_q      <= 1'b0;
      count_q     <= '0;
      latched_q   <= '0;
      overflow_q  <= 1'b0;
      latch_chg_q <= 1'b0;
      latch_upd_q <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      count_q     <= count_d;
      latched_q   <= latched_d;
      overflow_q  <= overflow_d;
      latch_chg_q <= latch_chg_d;
      latch_upd_q <= latch_chg_q;
    end
  end

  assign bus.tick      = tick_q;
  assign bus.count     = count_q;
  assign bus.latched   = latched_q;
  assign bus.latch_upd = latch_upd_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_rtc_timebase_counter.sv
// Directed bench for the stopwatch time base at CLK_DIV=4: a per-cycle vector table plus
// hand-written multi-cycle sequences. A 4-bit-count instance shares the stimulus for wrap checks.
module tb_rtc_timebase_counter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rtc_timebase_counter_if #(.CNT_W(24)) bus  ();
  rtc_timebase_counter_if #(.CNT_W(4))  bus4 ();

  rtc_timebase_counter #(.CLK_DIV(4), .PRESC_W(2), .CNT_W(24)) dut (
    .i_sclk    (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  rtc_timebase_counter #(.CLK_DIV(4), .PRESC_W(2), .CNT_W(4)) dut4 (
    .i_sclk    (clk),
    .i_reset_n (rst_n),
    .bus       (bus4.slave)
  );

  typedef struct {
    bit init;
    bit enb;
    bit latch;
    bit tick;
    int cnt;
    int lat;
    bit upd;
    bit ovf;
  } vec_t;

  vec_t vecs [19];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   ups;

  function automatic vec_t mkv(bit i, bit e, bit l, bit t, int c, int la, bit u, bit o);
    vec_t v;
    v.init = i; v.enb = e; v.latch = l;
    v.tick = t; v.cnt = c; v.lat = la; v.upd = u; v.ovf = o;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input bit i, input bit e, input bit l);
    bus.count_init  = i; bus.count_enb  = e; bus.latch_count  = l;
    bus4.count_init = i; bus4.count_enb = e; bus4.latch_count = l;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic cyc(input bit i, input bit e, input bit l);
    @(negedge clk);
    drive(i, e, l);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".tick"},  bus.tick,       0);
    chk({tag, ".count"}, bus.count,      0);
    chk({tag, ".lat"},   bus.latched,    0);
    chk({tag, ".upd"},   bus.latch_upd,  0);
    chk({tag, ".ovf"},   bus.overflow,   0);
    chk({tag, ".cnt4"},  bus4.count,     0);
    chk({tag, ".ovf4"},  bus4.overflow,  0);
  endtask

  initial begin
    //            init enb lat | tick cnt lat upd ovf
    vecs[0]  = mkv(1, 0, 0,   0, 0, 0, 0, 0);
    vecs[1]  = mkv(0, 1, 1,   0, 0, 0, 0, 0);
    vecs[2]  = mkv(0, 1, 1,   0, 0, 0, 0, 0);
    vecs[3]  = mkv(0, 1, 1,   0, 0, 0, 0, 0);
    vecs[4]  = mkv(0, 1, 1,   1, 1, 0, 0, 0);
    vecs[5]  = mkv(0, 1, 1,   0, 1, 1, 0, 0);
    vecs[6]  = mkv(0, 1, 1,   0, 1, 1, 1, 0);
    vecs[7]  = mkv(0, 1, 1,   0, 1, 1, 0, 0);
    vecs[8]  = mkv(0, 1, 1,   1, 2, 1, 0, 0);
    vecs[9]  = mkv(0, 1, 0,   0, 2, 1, 0, 0);
    vecs[10] = mkv(0, 1, 0,   0, 2, 1, 0, 0);
    vecs[11] = mkv(0, 0, 1,   0, 2, 2, 0, 0);
    vecs[12] = mkv(0, 0, 1,   0, 2, 2, 1, 0);
    vecs[13] = mkv(0, 1, 1,   0, 2, 2, 0, 0);
    vecs[14] = mkv(0, 1, 1,   1, 3, 2, 0, 0);
    vecs[15] = mkv(1, 1, 1,   0, 0, 0, 0, 0);
    vecs[16] = mkv(1, 1, 1,   0, 0, 0, 1, 0);
    vecs[17] = mkv(1, 1, 1,   0, 0, 0, 0, 0);
    vecs[18] = mkv(0, 0, 0,   0, 0, 0, 0, 0);

    drive(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    $display("reset: outputs sampled in reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Per-cycle vector table
    for (int k = 0; k < 19; k++) begin
      cyc(vecs[k].init, vecs[k].enb, vecs[k].latch);
      chk($sformatf("v%0d.tick", k), bus.tick,      vecs[k].tick);
      chk($sformatf("v%0d.cnt", k),  bus.count,     vecs[k].cnt);
      chk($sformatf("v%0d.lat", k),  bus.latched,   vecs[k].lat);
      chk($sformatf("v%0d.upd", k),  bus.latch_upd, vecs[k].upd);
      chk($sformatf("v%0d.ovf", k),  bus.overflow,  vecs[k].ovf);
      $display("vec %0d: in=%0d%0d%0d tick=%0d cnt=%0d lat=%0d upd=%0d ovf=%0d", k,
               vecs[k].init, vecs[k].enb, vecs[k].latch,
               bus.tick, bus.count, bus.latched, bus.latch_upd, bus.overflow);
    end

    // RUN for 40 cycles after reset + init
    do_reset();
    cyc(1, 0, 0);
    ups = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(0, 1, 1);
      chk($sformatf("run%0d.tick", i), bus.tick,    (i % 4 == 0) ? 1 : 0);
      chk($sformatf("run%0d.cnt", i),  bus.count,   i / 4);
      chk($sformatf("run%0d.lat", i),  bus.latched, (i - 1) / 4);
      ups += int'(bus.latch_upd);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 1);
      ups += int'(bus.latch_upd);
    end
    chk("run.final_cnt", bus.count,   10);
    chk("run.final_lat", bus.latched, 10);
    chk("run.upd_pulses", ups, 10);
    $display("run: count=%0d latched=%0d upd_pulses=%0d", bus.count, bus.latched, ups);

    // LAP hold at 5 while the live count advances to 8
    cyc(1, 0, 0);
    for (int i = 1; i <= 22; i++) cyc(0, 1, 1);
    chk("lap.pre_cnt", bus.count,   5);
    chk("lap.pre_lat", bus.latched, 5);
    ups = 0;
    for (int i = 23; i <= 34; i++) begin
      cyc(0, 1, 0);
      chk($sformatf("lap%0d.lat", i), bus.latched, 5);
      ups += int'(bus.latch_upd);
    end
    chk("lap.hold_upd", ups, 0);
    chk("lap.end_cnt", bus.count, 8);
    ups = 0;
    for (int i = 35; i <= 37; i++) begin
      cyc(0, 1, 1);
      if (i == 35) chk("lap.restore_lat", bus.latched, 8);
      ups += int'(bus.latch_upd);
    end
    chk("lap.restore_upd", ups, 1);
    $display("lap: restored latched, upd_pulses=%0d", ups);

    // Pause after two prescaler counts keeps the fraction
    cyc(1, 0, 0);
    cyc(0, 1, 1);
    cyc(0, 1, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 1);
      chk($sformatf("pause%0d.tick", i), bus.tick,  0);
      chk($sformatf("pause%0d.cnt", i),  bus.count, 0);
    end
    cyc(0, 1, 1);
    chk("pause.resume1_tick", bus.tick, 0);
    cyc(0, 1, 1);
    chk("pause.resume2_tick", bus.tick,  1);
    chk("pause.resume2_cnt",  bus.count, 1);
    $display("pause: tick=%0d count=%0d after 2 resumed cycles", bus.tick, bus.count);

    // Init + enable at count 7 with the prescaler one step from wrapping
    cyc(1, 0, 0);
    for (int i = 1; i <= 31; i++) cyc(0, 1, 1);
    chk("clr.pre_cnt", bus.count,   7);
    chk("clr.pre_lat", bus.latched, 7);
    cyc(0, 0, 1);
    chk("clr.quiet_upd", bus.latch_upd, 0);
    ups = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 1);
      chk($sformatf("clr%0d.tick", i), bus.tick,     0);
      chk($sformatf("clr%0d.cnt", i),  bus.count,    0);
      chk($sformatf("clr%0d.lat", i),  bus.latched,  0);
      ups += int'(bus.latch_upd);
    end
    chk("clr.upd_pulses", ups, 1);
    for (int j = 1; j <= 4; j++) begin
      cyc(0, 1, 1);
      chk($sformatf("clr.after%0d.tick", j), bus.tick, (j == 4) ? 1 : 0);
    end
    $display("clear: upd_pulses=%0d, first tick 4 cycles after release", ups);

    // Counter wrap on the 4-bit instance
    cyc(1, 0, 0);
    for (int i = 1; i <= 64; i++) begin
      cyc(0, 1, 1);
      if (i == 60) begin
        chk("wrap.cnt4_15", bus4.count,    15);
        chk("wrap.ovf4_pre", bus4.overflow, 0);
      end
    end
    chk("wrap.cnt4_0",  bus4.count,    0);
    chk("wrap.ovf4",    bus4.overflow, 1);
    chk("wrap.cnt24",   bus.count,     16);
    chk("wrap.ovf24",   bus.overflow,  0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1);
      chk($sformatf("wrap.sticky%0d", i), bus4.overflow, 1);
    end
    cyc(1, 0, 0);
    chk("wrap.init_ovf4", bus4.overflow, 0);
    chk("wrap.init_cnt4", bus4.count,    0);
    $display("wrap: overflow set on 15->0, cleared by init");

    // Asynchronous reset between edges
    for (int i = 1; i <= 10; i++) cyc(0, 1, 1);
    chk("arst.pre_cnt", bus.count, 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 1);
      chk($sformatf("arst.rel%0d.tick", i), bus.tick,      0);
      chk($sformatf("arst.rel%0d.upd", i),  bus.latch_upd, 0);
      chk($sformatf("arst.rel%0d.cnt", i),  bus.count,     0);
    end
    $display("async reset: outputs cleared between edges, quiet on release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_timebase_counter.md
# rtc_timebase_counter

Stopwatch time base and elapsed-time counter, directly downstream of the trigger/debounce control block. Divides `i_sclk` into 10 ms ticks and counts ticks in a 24-bit register. Maintains a display/lap register that either tracks the live count or freezes. The control block's `count_init`, `count_enb` and `latch_count` outputs drive it directly; its outputs feed the display formatter.

## Interface
- `CLK_DIV`, default 1_000_000: `i_sclk` cycles per tick; gives 10 ms at 100 MHz; legal range ≥ 2.
- `PRESC_W`, default 20: prescaler width; must satisfy 2^PRESC_W ≥ CLK_DIV.
- `CNT_W`, default 24: tick counter width.
- `i_sclk` in 1: system clock; all logic on the rising edge.
- `i_reset_n` in 1: reset, asynchronous, active-low.
- `i_count_init` in 1: synchronous clear of prescaler, count, latch and overflow.
- `i_count_enb` in 1: run prescaler/counter.
- `i_latch_count` in 1: 1 = display register tracks live count; 0 = display frozen (lap hold).
- `o_tick` out 1: one-cycle pulse per completed 10 ms interval.
- `o_count` out CNT_W: live elapsed ticks.
- `o_latched` out CNT_W: display/lap value.
- `o_latch_upd` out 1: one-cycle pulse when `o_latched` changes value.
- `o_overflow` out 1: sticky flag, set when the counter wraps.

## Operation
- Inputs are synchronous to `i_sclk`; no synchronizers.
- Priority per edge: reset > `i_count_init` > `i_count_enb`.
- **Init** (`i_count_init`=1):
  - Prescaler, `o_count`, `o_latched` and `o_overflow` go to 0; `o_tick` goes to 0.
  - `i_count_enb` is ignored that cycle.
  - `o_latch_upd` pulses only if `o_latched` was nonzero.
- **Prescaler**: increments when `i_count_enb`=1 and `i_count_init`=0. At value CLK_DIV-1 it returns to 0 and generates a tick. It holds when `i_count_enb`=0, so a pause keeps the sub-tick fraction.
- **Counter**: increments by 1 on the same edge the prescaler wraps.
  - At 2^CNT_W-1 it wraps to 0 and sets `o_overflow`.
  - `o_overflow` stays set until init or reset.
- **Latch**: each edge with `i_latch_count`=1 and no init, `o_latched` <= current `o_count` (pre-edge value). With `i_latch_count`=0, `o_latched` holds.
- **`o_latch_upd`**: registered; high for the cycle after any edge on which `o_latched` changed value.
- The block has no FSM of its own. Mode is defined by the input combination:
  - CLEAR: init=1.
  - RUN: enb=1, latch=1.
  - LAP: enb=1, latch=0.
  - STOP: enb=0.

## Timing
- Reset values: all outputs 0; prescaler 0.
- Tick latency:
  - The prescaler wraps on edge N.
  - `o_count` shows the new value and `o_tick`=1 during cycle N+1; both change together.
  - First tick after init and enable: `o_tick` high exactly CLK_DIV cycles after the first enabled edge.
- `o_latched` lags `o_count` by one cycle while latch=1. `o_latch_upd` lags `o_latched` by one cycle.
- Latch 0→1 while running: `o_latched` catches up on the first latch=1 edge; at most one `o_latch_upd` pulse.
- Enable deasserted on the wrap edge: the wrap still takes effect because the edge samples enb=1. The next cycle holds.
- Init and enable both high: clear wins; no tick.
- Asynchronous reset mid-count: everything to 0 immediately; no `o_tick` or `o_latch_upd` on release.

## Structure
- Shared package `rtc_pkg`:
  - RTC_CLK_DIV_10MS = 1_000_000
  - RTC_CNT_W = 24
  - RTC_PRESC_W = 20
- Sub-module `rtc_prescaler`:
  - Inputs: clear and enable.
  - Output: the wrap strobe.
  - Parameterized by CLK_DIV and PRESC_W.
- Counter, latch, overflow and update logic live in the top module.

## Test plan
Benches run with CLK_DIV=4.
- **Reset, then init 1 cycle, then enb=1 latch=1 for 40 cycles:**
  - `o_tick` pulses every 4 cycles, first 4 cycles after the enable edge.
  - `o_count` ends at 10.
  - `o_latched` = `o_count` delayed 1 cycle.
  - `o_latch_upd` pulses 10 times.
- **Running at `o_count`=5, drop latch for 12 cycles, then restore:**
  - `o_latched` holds 5 and `o_count` reaches 8.
  - On restore, `o_latched`=8 one cycle later with a single `o_latch_upd` pulse.
- **Pause mid-interval:** enb=0 after 2 prescaler counts, hold 20 cycles, re-enable. Next `o_tick` comes 2 enabled cycles later; the count is unchanged during the pause.
- **Wrap:** preload via CNT_W=4, run 16 ticks. `o_count` wraps 15→0 and `o_overflow`=1 until init clears it.
- **Init and enb both high for 3 cycles while `o_count`=7:**
  - All counters go to 0 and no tick occurs.
  - One `o_latch_upd` pulse when `o_latched` drops to 0.
- **Async reset asserted between clock edges mid-run:** outputs go to 0 before the next edge; no pulses on release.
